seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the core's combinational ALU.
- Adds XOR, SLTU, signed SLT, a correct arithmetic right shift, and RV32M multiply/divide/remainder.
- Multiply/divide run iteratively, one bit per cycle, behind a valid/ready handshake.
- Sits in the execute stage. The control unit stalls the PC while in_ready or out_valid indicate an operation is in flight.

---
 rtl/seq_alu.sv | 211 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: single-cycle basic ops plus iterative RV32M
// multiply/divide behind a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a request; operands and op captured on in_valid
// MUL   | shift-add, one multiplier bit per cycle
// DIV   | restoring shift-subtract, one quotient bit per cycle
// DONE  | result presented until out_ready
module seq_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic [4:0]      alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            illegal_op
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SLT    = 5'b00101;
    localparam logic [4:0] OP_SLTU   = 5'b00110;
    localparam logic [4:0] OP_SLL    = 5'b00111;
    localparam logic [4:0] OP_SRL    = 5'b01000;
    localparam logic [4:0] OP_SRA    = 5'b01001;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_REM    = 5'b10110;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sub_q, sub_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              ill_q, ill_d;

    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   basic_res;
    logic              basic_ill;
    logic              is_mul, is_div;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_nx, prod_fix;
    logic [XLEN:0]     div_sh, div_diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_nx, quo_nx, rem_fix, quo_fix;

    assign shamt  = srcB[SHW-1:0];
    assign is_mul = (alu_op[4:2] == 3'b100);
    assign is_div = (alu_op[4:2] == 3'b101);

    always_comb begin
        basic_res = '0;
        basic_ill = 1'b0;
        case (alu_op)
            OP_ADD:  basic_res = srcA + srcB;
            OP_SUB:  basic_res = srcA - srcB;
            OP_AND:  basic_res = srcA & srcB;
            OP_OR:   basic_res = srcA | srcB;
            OP_XOR:  basic_res = srcA ^ srcB;
            OP_SLT:  basic_res = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(srcB)};
            OP_SLTU: basic_res = {{(XLEN-1){1'b0}}, srcA < srcB};
            OP_SLL:  basic_res = srcA << shamt;
            OP_SRL:  basic_res = srcA >> shamt;
            OP_SRA:  basic_res = $signed(srcA) >>> shamt;
            default: basic_ill = 1'b1;
        endcase
    end

    // Iterative ops work on magnitudes; signs are restored on the last cycle.
    always_comb begin
        a_neg = (alu_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && srcA[XLEN-1];
        b_neg = (alu_op inside {OP_MULH, OP_DIV, OP_REM}) && srcB[XLEN-1];
        a_mag = a_neg ? -srcA : srcA;
        b_mag = b_neg ? -srcB : srcB;
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        prod_nx  = {mul_sum, lo_q[XLEN-1:1]};
        prod_fix = neg_q ? -prod_nx : prod_nx;

        div_sh   = {acc_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        q_bit    = ~div_diff[XLEN];
        rem_nx   = q_bit ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
        quo_nx   = {lo_q[XLEN-2:0], q_bit};
        quo_fix  = neg_q ? -quo_nx : quo_nx;
        rem_fix  = rneg_q ? -rem_nx : rem_nx;
    end

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sub_d = alu_op[1:0];
                    acc_d = '0;
                    cnt_d = '0;
                    if (is_mul) begin
                        opnd_d  = a_mag;
                        lo_d    = b_mag;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = 1'b0;
                        ill_d   = 1'b0;
                        state_d = MUL;
                    end else if (is_div) begin
                        // Zero divisor must yield an all-ones quotient regardless of sign.
                        lo_d    = a_mag;
                        opnd_d  = b_mag;
                        neg_d   = (a_neg ^ b_neg) && (srcB != '0);
                        rneg_d  = a_neg;
                        ill_d   = 1'b0;
                        state_d = DIV;
                    end else begin
                        res_d   = basic_res;
                        ill_d   = basic_ill;
                        state_d = DONE;
                    end
                end
            end
            MUL: begin
                acc_d = prod_nx[2*XLEN-1:XLEN];
                lo_d  = prod_nx[XLEN-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    res_d   = (sub_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DIV: begin
                acc_d = rem_nx;
                lo_d  = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    res_d   = sub_q[1] ? rem_fix : quo_fix;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sub_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign ALUResult  = res_q;
    assign Zero       = (res_q == '0);
    assign illegal_op = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu: basic ops, RV32M corner cases, latency,
// back-pressure and mid-operation reset.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] srcA, srcB;
    logic [4:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        illegal_op;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .srcA       (srcA),
        .srcB       (srcB),
        .alu_op     (alu_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request from IDLE, scramble inputs after acceptance, and
    // return the number of edges from acceptance until out_valid is sampled.
    task automatic issue(input string tag, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b, output int lat);
        check_val({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        alu_op   = op;
        srcA     = a;
        srcB     = b;
        tick();
        in_valid = 1'b0;
        alu_op   = 5'b01111;
        srcA     = ~a;
        srcB     = ~b;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic exp_ill,
                       input int exp_lat);
        int lat;
        issue(tag, op, a, b, lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_res"}, ALUResult, exp);
        check_val({tag, "_zero"}, {31'b0, Zero}, {31'b0, exp == 32'd0});
        check_val({tag, "_ill"}, {31'b0, illegal_op}, {31'b0, exp_ill});
        tick();
        check_val({tag, "_retired"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        reset     = 1'b1;
        in_valid  = 1'b0;
        srcA      = '0;
        srcB      = '0;
        alu_op    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check_val("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("rst_result", ALUResult, 32'd0);
        check_val("rst_zero", {31'b0, Zero}, 32'd1);
        check_val("rst_ill", {31'b0, illegal_op}, 32'd0);

        run("add_wrap", 5'b00000, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 1);
        run("sub",      5'b00001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1);
        run("and",      5'b00010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1);
        run("or",       5'b00011, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 1'b0, 1);
        run("sra",      5'b01001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1);
        run("srl",      5'b01000, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1);
        run("sll_mask", 5'b00111, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1);
        run("sltu",     5'b00110, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
        run("slt",      5'b00101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1);
        run("slt_neg",  5'b00101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);

        run("mul",      5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
        run("mul_small",5'b10000, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0, 33);
        run("mulh",     5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33);
        run("mulhu",    5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        run("mulhsu",   5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);

        run("div_ovf",  5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
        run("rem_ovf",  5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33);
        run("divu_z",   5'b10101, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 33);
        run("remu_z",   5'b10111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0, 33);
        run("div_z_neg",5'b10100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 33);
        run("rem_z_neg",5'b10110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b0, 33);
        run("divu",     5'b10101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 33);
        run("remu",     5'b10111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 33);
        run("div_neg",  5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33);
        run("rem_neg",  5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33);

        // Back-pressure: result held in DONE, a stray request is ignored.
        out_ready = 1'b0;
        issue("bp", 5'b00100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat);
        check_val("bp_lat", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                alu_op   = 5'b00000;
                srcA     = 32'd1;
                srcB     = 32'd1;
            end
            tick();
            in_valid = 1'b0;
            check_val("bp_hold_res", ALUResult, 32'hFF00_FF00);
            check_val("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
            check_val("bp_hold_out_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check_val("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        check_val("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("bp_release_res", ALUResult, 32'hFF00_FF00);

        // Reset during a DIVU abandons it.
        in_valid = 1'b1;
        alu_op   = 5'b10101;
        srcA     = 32'h1234_5678;
        srcB     = 32'h0000_0003;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_val("mid_busy", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_val("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("mid_rst_res", ALUResult, 32'd0);
        check_val("mid_rst_zero", {31'b0, Zero}, 32'd1);
        tick();
        check_val("mid_rst_stays_idle", {31'b0, out_valid}, 32'd0);

        run("add_after", 5'b00000, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234, 1'b0, 1);
        run("illegal",   5'b11111, 32'h0000_1000, 32'h0000_0234, 32'h0000_0000, 1'b1, 1);
        run("illegal2",  5'b01010, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
        run("legal_clr", 5'b00100, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
